// File: rtl/pueo_trig_queue_pkg.sv
// Shared types and constants for the aclk-domain trigger queue.
package pueo_trig_pkg;

  localparam int TRIG_TIME_W  = 16;
  localparam int TRIG_EVNUM_W = 16;

  typedef struct packed {
    logic [TRIG_EVNUM_W-1:0] evnum;
    logic [TRIG_TIME_W-1:0]  trig_time;
  } trig_entry_t;

  localparam logic [15:0] DROP_SAT = 16'hFFFF;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == DROP_SAT) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/pueo_trig_queue_fifo.sv
// Distributed-RAM FIFO with a registered first-word-fall-through head and synchronous flush.
module trig_fifo_fwft #(
  parameter int W     = 32,
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          wr_en,
  input  logic [W-1:0]  wr_data,
  input  logic          rd_ready,
  output logic [W-1:0]  rd_data,
  output logic          rd_valid,
  output logic [CW-1:0] count
);

  logic [W-1:0]  ram [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [W-1:0]  dout_q, dout_d;
  logic          valid_q, valid_d;
  logic          pop, load, ram_has, ram_wr;

  // count includes the head register; the RAM holds count - valid entries
  always_comb begin
    pop      = valid_q & rd_ready;
    load     = ~valid_q | pop;
    ram_has  = (count_q - CW'(valid_q)) != '0;
    ram_wr   = wr_en & ~(load & ~ram_has);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    dout_d   = dout_q;
    valid_d  = valid_q;
    if (flush) begin
      ram_wr   = 1'b0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      dout_d   = '0;
      valid_d  = 1'b0;
    end else begin
      if (ram_wr) wr_ptr_d = wr_ptr_q + AW'(1);
      if (load) begin
        if (ram_has) begin
          dout_d   = ram[rd_ptr_q];
          rd_ptr_d = rd_ptr_q + AW'(1);
          valid_d  = 1'b1;
        end else if (wr_en) begin
          dout_d  = wr_data;
          valid_d = 1'b1;
        end else begin
          valid_d = 1'b0;
        end
      end
      count_d = count_q + CW'(wr_en) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (ram_wr) ram[wr_ptr_q] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      dout_q   <= '0;
      valid_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      dout_q   <= dout_d;
      valid_q  <= valid_d;
    end
  end

  assign rd_data  = dout_q;
  assign rd_valid = valid_q;
  assign count    = count_q;

endmodule

// File: rtl/pueo_trig_queue.sv
// Trigger queue: holdoff, event-buffer occupancy limit, event numbering and drop statistics
// in front of an AXI-Stream-style FWFT output.
module pueo_trig_queue #(
  parameter int TIME_BITS    = 16,
  parameter int EVNUM_BITS   = 16,
  parameter int DEPTH        = 16,
  parameter int NBUF         = 4,
  parameter int HOLDOFF_BITS = 8
) (
  input  logic                            aclk_i,
  input  logic                            aclk_rst_i,
  input  logic                            run_rst_i,
  input  logic                            run_en_i,
  input  logic [HOLDOFF_BITS-1:0]         holdoff_i,
  input  logic [TIME_BITS-1:0]            trig_time_i,
  input  logic                            trig_valid_i,
  output logic [EVNUM_BITS+TIME_BITS-1:0] m_axis_tdata,
  output logic                            m_axis_tvalid,
  input  logic                            m_axis_tready,
  input  logic                            done_i,
  output logic [$clog2(DEPTH+1)-1:0]      queued_o,
  output logic [$clog2(NBUF+1)-1:0]       inflight_o,
  output logic [15:0]                     drop_count_o,
  output logic                            overflow_o,
  output logic                            err_o
);
  import pueo_trig_pkg::*;

  localparam int QW = $clog2(DEPTH + 1);
  localparam int RW = $clog2(NBUF + 1);
  localparam int SW = ((QW > RW) ? QW : RW) + 1;

  logic [EVNUM_BITS-1:0]   evnum_q, evnum_d;
  logic [HOLDOFF_BITS-1:0] hcnt_q, hcnt_d;
  logic [RW-1:0]           r_q, r_d;
  logic [15:0]             drop_q, drop_d;
  logic                    ovf_q, ovf_d, err_q, err_d;
  logic [QW-1:0]           q_cnt;
  logic [SW-1:0]           occ;
  logic                    active, room, accept, drop, pop, done_ok;

  // capacity is judged on registered counts, so a slot freed this cycle is usable next cycle
  always_comb begin
    occ     = SW'(q_cnt) + SW'(r_q);
    room    = (SW'(q_cnt) < SW'(DEPTH)) && (occ < SW'(NBUF));
    active  = trig_valid_i & run_en_i & ~run_rst_i;
    accept  = active & (hcnt_q == '0) & room;
    drop    = active & ~accept;
    pop     = m_axis_tvalid & m_axis_tready & ~run_rst_i;
    done_ok = done_i & ((r_q != '0) | pop);
    evnum_d = evnum_q;
    hcnt_d  = hcnt_q;
    r_d     = r_q;
    drop_d  = drop_q;
    ovf_d   = ovf_q;
    err_d   = err_q;
    if (run_rst_i) begin
      evnum_d = '0;
      hcnt_d  = '0;
      r_d     = '0;
      drop_d  = '0;
      ovf_d   = 1'b0;
      err_d   = 1'b0;
    end else begin
      if (accept) begin
        evnum_d = evnum_q + EVNUM_BITS'(1);
        hcnt_d  = holdoff_i;
      end else if (hcnt_q != '0) begin
        hcnt_d = hcnt_q - HOLDOFF_BITS'(1);
      end
      r_d = r_q + RW'(pop) - RW'(done_ok);
      if (drop) drop_d = sat_inc16(drop_q);
      if (drop & ~room) ovf_d = 1'b1;
      if (done_i & ~done_ok) err_d = 1'b1;
    end
  end

  always_ff @(posedge aclk_i or posedge aclk_rst_i) begin
    if (aclk_rst_i) begin
      evnum_q <= '0;
      hcnt_q  <= '0;
      r_q     <= '0;
      drop_q  <= '0;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      evnum_q <= evnum_d;
      hcnt_q  <= hcnt_d;
      r_q     <= r_d;
      drop_q  <= drop_d;
      ovf_q   <= ovf_d;
      err_q   <= err_d;
    end
  end

  trig_fifo_fwft #(
    .W    (EVNUM_BITS + TIME_BITS),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk     (aclk_i),
    .rst     (aclk_rst_i),
    .flush   (run_rst_i),
    .wr_en   (accept),
    .wr_data ({evnum_q, trig_time_i}),
    .rd_ready(m_axis_tready),
    .rd_data (m_axis_tdata),
    .rd_valid(m_axis_tvalid),
    .count   (q_cnt)
  );

  assign queued_o     = q_cnt;
  assign inflight_o   = r_q;
  assign drop_count_o = drop_q;
  assign overflow_o   = ovf_q;
  assign err_o        = err_q;

endmodule

// File: tb/tb_pueo_trig_queue.sv
// Bench for pueo_trig_queue: directed scenarios plus random traffic against a queue-based model.
module tb_pueo_trig_queue;
  import pueo_trig_pkg::*;

  localparam int TB    = 16;
  localparam int EB    = 16;
  localparam int DEPTH = 4;
  localparam int NBUF  = 6;
  localparam int HB    = 8;
  localparam int QW    = $clog2(DEPTH + 1);
  localparam int RW    = $clog2(NBUF + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          run_rst = 1'b0;
  logic          run_en = 1'b0;
  logic [HB-1:0] hold = '0;
  logic [TB-1:0] tt = '0;
  logic          tv = 1'b0;
  logic          rdy = 1'b0;
  logic          done = 1'b0;
  logic [EB+TB-1:0] tdata;
  logic          tvalid;
  logic [QW-1:0] queued;
  logic [RW-1:0] inflight;
  logic [15:0]   dropc;
  logic          ovf, err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pueo_trig_queue #(
    .TIME_BITS(TB), .EVNUM_BITS(EB), .DEPTH(DEPTH), .NBUF(NBUF), .HOLDOFF_BITS(HB)
  ) dut (
    .aclk_i(clk), .aclk_rst_i(rst), .run_rst_i(run_rst), .run_en_i(run_en),
    .holdoff_i(hold), .trig_time_i(tt), .trig_valid_i(tv),
    .m_axis_tdata(tdata), .m_axis_tvalid(tvalid), .m_axis_tready(rdy),
    .done_i(done), .queued_o(queued), .inflight_o(inflight),
    .drop_count_o(dropc), .overflow_o(ovf), .err_o(err)
  );

  // reference model state
  trig_entry_t mq[$];
  int          m_r, m_drop, m_cyc, m_next_ok, m_ev;
  bit          m_ovf, m_err;
  bit          cfg_en = 1'b1;
  logic [HB-1:0] cfg_hold = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_r = 0; m_drop = 0; m_ev = 0; m_ovf = 1'b0; m_err = 1'b0;
    m_next_ok = m_cyc;
  endtask

  task automatic compare_all();
    check("tvalid", tvalid, mq.size() > 0);
    if (mq.size() > 0) check("tdata", tdata, mq[0]);
    check("queued", queued, mq.size());
    check("inflight", inflight, m_r);
    check("drop", dropc, m_drop);
    check("overflow", ovf, m_ovf);
    check("err", err, m_err);
  endtask

  // one clock: compare outputs, drive inputs, advance the model by the spec rules
  task automatic step(input bit v, input logic [TB-1:0] t, input bit r, input bit d, input bit rr);
    bit pop, act, room, acc, done_ok;
    trig_entry_t e;
    @(negedge clk);
    compare_all();
    tv = v; tt = t; rdy = r; done = d; run_rst = rr;
    run_en = cfg_en; hold = cfg_hold;
    if (rr) begin
      mq.delete();
      m_r = 0; m_drop = 0; m_ev = 0; m_ovf = 1'b0; m_err = 1'b0;
      m_next_ok = m_cyc + 1;
    end else begin
      pop     = (mq.size() > 0) && r;
      act     = v && cfg_en;
      room    = (mq.size() < DEPTH) && (mq.size() + m_r < NBUF);
      acc     = act && room && (m_cyc >= m_next_ok);
      done_ok = d && (m_r > 0 || pop);
      if (act && !acc) begin
        if (m_drop < 65535) m_drop++;
        if (!room) m_ovf = 1'b1;
      end
      if (d && !done_ok) m_err = 1'b1;
      if (pop) begin
        void'(mq.pop_front());
        m_r++;
      end
      if (done_ok) m_r--;
      if (acc) begin
        e.evnum     = m_ev[EB-1:0];
        e.trig_time = t;
        mq.push_back(e);
        m_ev++;
        m_next_ok = m_cyc + int'(cfg_hold) + 1;
      end
    end
    m_cyc++;
  endtask

  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    m_cyc = 0;
    model_reset();
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_tvalid", tvalid, 0);
    check("rst_tdata", tdata, 0);
    check("rst_queued", queued, 0);
    check("rst_inflight", inflight, 0);
    check("rst_drop", dropc, 0);
    check("rst_ovf", ovf, 0);
    check("rst_err", err, 0);
    @(negedge clk);
    rst = 1'b0;

    // basic back-to-back accepts
    cfg_en = 1'b1; cfg_hold = '0;
    step(1, 16'h0100, 1, 0, 0);
    after_edge();
    check("basic_t0", tdata, {16'd0, 16'h0100});
    step(1, 16'h0101, 1, 0, 0);
    after_edge();
    check("basic_t1", tdata, {16'd1, 16'h0101});
    check("basic_drop", dropc, 0);
    step(0, '0, 1, 1, 0);
    step(0, '0, 1, 1, 0);
    step(0, '0, 0, 0, 1);

    // holdoff of 3 with a trigger every cycle
    cfg_hold = 8'd3;
    for (int i = 0; i < 10; i++) step(1, TB'($urandom), 1, 0, 0);
    after_edge();
    check("hold_drop", dropc, 7);
    check("hold_ovf", ovf, 0);
    check("hold_accepts", inflight, 3);
    cfg_hold = '0;
    step(0, '0, 0, 0, 1);

    // occupancy limit
    for (int k = 0; k < 8; k++) begin
      step(1, TB'($urandom), 1, 0, 0);
      step(0, '0, 1, 0, 0);
    end
    after_edge();
    check("cap_drop", dropc, 2);
    check("cap_ovf", ovf, 1);
    check("cap_inflight", inflight, NBUF);
    step(0, '0, 0, 1, 0);
    step(1, TB'($urandom), 0, 0, 0);
    after_edge();
    check("cap_tvalid", tvalid, 1);
    check("cap_evnum", tdata[31:16], 6);
    step(0, '0, 0, 0, 1);

    // queue full under backpressure, then drain with random stalls
    for (int i = 0; i < 6; i++) step(1, TB'($urandom), 0, 0, 0);
    after_edge();
    check("full_queued", queued, DEPTH);
    check("full_drop", dropc, 2);
    for (int i = 0; i < 8; i++) step(0, '0, 1'($urandom_range(0, 1)), 0, 0);
    for (int i = 0; i < 4; i++) step(0, '0, 1, 0, 0);
    step(0, '0, 0, 0, 1);

    // simultaneous accept, pop and done
    step(1, TB'($urandom), 0, 0, 0);
    step(0, '0, 1, 0, 0);
    step(1, TB'($urandom), 0, 0, 0);
    step(1, TB'($urandom), 1, 1, 0);
    after_edge();
    check("sim_queued", queued, 1);
    check("sim_inflight", inflight, 1);
    step(0, '0, 0, 1, 0);
    step(0, '0, 0, 1, 0);
    after_edge();
    check("sim_err", err, 1);
    step(0, '0, 1, 1, 0);
    after_edge();
    check("sim_pop_done_r0", inflight, 0);
    step(0, '0, 0, 0, 1);

    // run reset from a populated state
    step(1, TB'($urandom), 0, 0, 0);
    step(0, '0, 1, 0, 0);
    step(1, TB'($urandom), 0, 0, 0);
    step(0, '0, 1, 0, 0);
    cfg_hold = 8'd2;
    for (int i = 0; i < 8; i++) step(1, TB'($urandom), 0, 0, 0);
    after_edge();
    check("rr_pre_queued", queued, 3);
    check("rr_pre_inflight", inflight, 2);
    check("rr_pre_drop", dropc, 5);
    step(1, TB'($urandom), 1, 1, 1);
    after_edge();
    check("rr_tvalid", tvalid, 0);
    check("rr_queued", queued, 0);
    check("rr_inflight", inflight, 0);
    check("rr_drop", dropc, 0);
    cfg_hold = '0;
    step(1, TB'($urandom), 0, 0, 0);
    after_edge();
    check("rr_evnum", tdata[31:16], 0);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      cfg_en   = ($urandom_range(0, 15) != 0);
      cfg_hold = HB'($urandom_range(0, 3));
      step(1'($urandom_range(0, 1)), TB'($urandom), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 3) == 0), ($urandom_range(0, 63) == 0));
    end

    // asynchronous reset in the middle of traffic
    cfg_en = 1'b1; cfg_hold = '0;
    step(0, '0, 0, 0, 1);
    for (int i = 0; i < 3; i++) step(1, TB'($urandom), 0, 0, 0);
    step(1, TB'($urandom), 1, 1, 0);
    #2 rst = 1'b1;
    #1;
    check("arst_tvalid", tvalid, 0);
    check("arst_tdata", tdata, 0);
    check("arst_queued", queued, 0);
    check("arst_inflight", inflight, 0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    tv = 1'b0; rdy = 1'b0; done = 1'b0;
    step(1, 16'h0ABC, 1, 0, 0);
    step(0, '0, 0, 0, 0);
    @(negedge clk);
    compare_all();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
